pipe_reg_chain: RTL
===================

Name: pipe_reg_chain

Overview:
Parametrised pipeline register chain for the inter-stage boundaries (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Replaces the fixed-field pause-gated registers with a generic payload bus.
- Uses a valid/ready handshake with a 2-entry skid buffer per stage, so upstream ready is fully registered.
- Adds synchronous flush (branch/exception squash) and an occupancy count.
- DEPTH skid stages are chained; a stall propagates backward one stage per cycle, and no data is lost or duplicated.

Parameters:
DATA_W, 32, payload width in bits; callers concatenate control and data fields.
DEPTH, 1, number of chained skid stages (1..8).
CNT_W, $clog2(2*DEPTH+1), width of the occupancy count.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous squash of every entry in the chain
in_valid  in  1  upstream offers in_data
in_ready  out  1  chain accepts in_data this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  out_data holds a valid entry
out_ready  in  1  downstream consumes out_data this cycle
out_data  out  DATA_W  downstream payload; forced to all-zero when out_valid=0
occupancy  out  CNT_W  number of valid entries held in the chain (0..2*DEPTH)

Behaviour:
- Handshake:
  - Transfer on the input side when in_valid & in_ready; on the output side when out_valid & out_ready.
  - in_valid/in_data must be held until accepted.
  - in_ready never depends combinationally on out_ready.
- Per-stage state (stage k = 0..DEPTH-1):
  - Registers: main (m_valid, m_data) and skid (s_valid, s_data).
  - States: EMPTY (m=0, s=0), ONE (m=1, s=0), FULL (m=1, s=1).
  - Stage in_ready = ~s_valid (a register).
  - Stage out_valid = m_valid; stage out_data = m_valid ? m_data : 0.
- Transitions (acc = input transfer, pop = output transfer):
  - EMPTY, acc: load main, go to ONE.
  - ONE, acc & pop: main <= input, stay ONE.
  - ONE, acc & ~pop: load skid, go to FULL.
  - ONE, ~acc & pop: go to EMPTY.
  - FULL, pop: main <= skid, go to ONE (no acc is possible in FULL).
  - Any state, no event: hold.
- Chain wiring:
  - Stage 0 input is the block input; stage DEPTH-1 output is the block output.
  - Stage k output feeds stage k+1 input.
- Latency: an entry accepted in cycle t with no backpressure appears on out_valid in cycle t+DEPTH.
- Throughput: 1 entry per cycle sustained.
- Occupancy:
  - Registered; updated each cycle by +acc(block) - pop(block).
  - Always equals the sum of m_valid and s_valid over all stages.
- Flush:
  - Clears every m_valid and s_valid in the next cycle; occupancy becomes 0 and in_ready becomes 1.
  - Flush wins over a simultaneous input transfer: the input is dropped, yet in_ready was high, so upstream treats it as accepted.
  - A simultaneous output transfer still completes; downstream sees it.
  - Data registers need not clear; only valid bits clear.
- Reset:
  - All valids 0, occupancy 0, out_valid 0, out_data 0.
  - in_ready is 1 from the first cycle after rst deasserts; in_ready is 0 while rst is high.
  - Inputs are ignored while rst is high.
  - Reset mid-transfer discards all contents.
- Boundary conditions:
  - Chain completely full (occupancy = 2*DEPTH): in_ready = 0.
  - DEPTH = 1 degenerates to a single skid buffer.
  - out_ready high with out_valid low has no effect.
  - Occupancy never wraps or underflows.

Decomposition:
- Shared package pipe_pkg holds:
  - the stage-state encoding (EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11);
  - the MAX_DEPTH = 8 constant;
  - the zero-bubble payload constant.
- Sub-module pipe_skid_stage (one skid stage: DATA_W parameter, clk/rst/flush, in/out handshake) is instantiated DEPTH times in a generate loop.
- The top level adds chain wiring and the occupancy counter only.

Test Plan:
1. DEPTH=3, out_ready=1, feed 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 in cycles 3, 4, 5; occupancy peaks at 3.
2. DEPTH=1, out_ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, in_ready falls after the second accept, 0xC held; occupancy = 2. Raise out_ready -> 0xA, 0xB, 0xC emerge in order, no gaps after the first.
3. DEPTH=2, random in_valid/out_ready at 50% for 1000 cycles -> output sequence equals input sequence; occupancy always equals accepts minus pops; out_data = 0 whenever out_valid = 0.
4. DEPTH=2, fill to occupancy 4, pulse flush together with an input 0x55 -> next cycle out_valid = 0, occupancy = 0, in_ready = 1; 0x55 never appears.
5. Assert rst for 1 cycle while occupancy = 3 -> out_valid = 0, out_data = 0, occupancy = 0; in_ready = 1 the cycle after rst drops.
6. DEPTH=1, out_ready toggling every cycle with in_valid constantly 1 -> in_ready never combinationally follows out_ready; every accepted value appears exactly once.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the pipeline register chain:
//               skid-stage state encoding, depth limit and the all-zero
//               payload driven while a stage holds no valid entry.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // The encoding doubles as the valid bits: bit 0 = main valid,
  // bit 1 = skid valid. ONE -> FULL only ever sets bit 1.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } stage_state_t;

  localparam int unsigned MAX_DEPTH  = 8;
  localparam int unsigned MAX_DATA_W = 1024;

  // Sliced down to the payload width at the point of use.
  localparam logic [MAX_DATA_W-1:0] ZERO_PAYLOAD = '0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : One valid/ready pipeline stage with a 2-entry skid buffer.
//               Upstream ready is the inverted skid-valid register, so it
//               never depends combinationally on downstream ready.
// Ports       : clk, rst (sync, active-high), flush (sync squash)
//               in_valid/in_ready/in_data    - upstream handshake
//               out_valid/out_ready/out_data - downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  import pipe_pkg::*;

  stage_state_t      r_state;
  logic [DATA_W-1:0] r_m_data;
  logic [DATA_W-1:0] r_s_data;
  logic              w_acc;
  logic              w_pop;

  assign in_ready  = ~r_state[1];
  assign out_valid = r_state[0];
  assign out_data  = out_valid ? r_m_data : ZERO_PAYLOAD[DATA_W-1:0];

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_m_data <= '0;
      r_s_data <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_m_data <= in_data;
            r_state  <= ONE;
          end
        end
        ONE: begin
          if (w_acc && w_pop) begin
            r_m_data <= in_data;
          end else if (w_acc) begin
            r_s_data <= in_data;
            r_state  <= FULL;
          end else if (w_pop) begin
            r_state  <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the pop can happen.
          if (w_pop) begin
            r_m_data <= r_s_data;
            r_state  <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
      // Squash only the valid bits; stale data is masked by out_data.
      if (flush) begin
        r_state <= EMPTY;
      end
    end
  end

endmodule : pipe_skid_stage
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain
// Description : DEPTH chained skid stages carrying a generic payload with
//               valid/ready handshake, synchronous flush and a registered
//               occupancy count (0..2*DEPTH).
// Ports       : clk, rst (sync, active-high), flush (sync squash)
//               in_valid/in_ready/in_data    - upstream handshake
//               out_valid/out_ready/out_data - downstream handshake
//               occupancy                    - valid entries held
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = $clog2(2*DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);
  import pipe_pkg::*;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH out of range");
  end

  // Index k is the boundary in front of stage k; index DEPTH is the output.
  logic [DEPTH:0]    w_valid;
  logic [DEPTH:0]    w_ready;
  logic [DATA_W-1:0] w_data [DEPTH+1];

  logic              w_blk_acc;
  logic              w_blk_pop;
  logic [CNT_W-1:0]  r_occ;

  assign w_valid[0]     = in_valid;
  assign w_data[0]      = in_data;
  assign w_ready[DEPTH] = out_ready;

  // Held low during reset so upstream cannot believe a drop was accepted.
  assign in_ready  = w_ready[0] & ~rst;
  assign out_valid = w_valid[DEPTH];
  assign out_data  = w_data[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_skid_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (w_valid[k]),
      .in_ready  (w_ready[k]),
      .in_data   (w_data[k]),
      .out_valid (w_valid[k+1]),
      .out_ready (w_ready[k+1]),
      .out_data  (w_data[k+1])
    );
  end

  assign w_blk_acc = in_valid & in_ready;
  assign w_blk_pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else if (w_blk_acc && !w_blk_pop) begin
      r_occ <= r_occ + C_CNT_ONE;
    end else if (!w_blk_acc && w_blk_pop) begin
      r_occ <= r_occ - C_CNT_ONE;
    end
  end

  assign occupancy = r_occ;

endmodule : pipe_reg_chain
`default_nettype wire
